// File: rtl/battle_pkg.sv
// Shared types and ROM field indices for the battle turn sequencer.
package battle_pkg;

    typedef enum logic [4:0] {
        TY_NORMAL, TY_FIRE, TY_WATER, TY_ELECTRIC, TY_GRASS, TY_ICE,
        TY_FIGHTING, TY_POISON, TY_GROUND, TY_FLYING, TY_PSYCHIC, TY_BUG,
        TY_ROCK, TY_GHOST, TY_DRAGON, TY_DARK, TY_STEEL, TY_FAIRY, TY_NONE
    } mon_type_e;

    localparam logic [7:0] PHYSICAL = 8'd1;
    localparam logic [7:0] SPECIAL  = 8'd0;

    localparam logic [2:0] STAT_TYPE1 = 3'd0;
    localparam logic [2:0] STAT_TYPE2 = 3'd1;
    localparam logic [2:0] STAT_HP    = 3'd2;
    localparam logic [2:0] STAT_ATK   = 3'd3;
    localparam logic [2:0] STAT_DEF   = 3'd4;
    localparam logic [2:0] STAT_SPA   = 3'd5;
    localparam logic [2:0] STAT_SPD   = 3'd6;
    localparam logic [2:0] STAT_SPE   = 3'd7;

    localparam logic [2:0] MV_TYPE = 3'd0;
    localparam logic [2:0] MV_CAT  = 3'd1;
    localparam logic [2:0] MV_POW  = 3'd2;
    localparam logic [2:0] MV_ACC  = 3'd3;
    localparam logic [2:0] MV_PP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_SPEED, ST_FETCH, ST_CALC, ST_APPLY, ST_DONE
    } turn_state_e;

endpackage

// File: rtl/damage_calc.sv
// Combinational damage: scaled attack minus defence, floored at 1, plus STAB bonus.
module damage_calc
    import battle_pkg::*;
(
    input  logic [7:0] power,
    input  logic [7:0] atk_stat,
    input  logic [7:0] def_stat,
    input  logic [7:0] move_type,
    input  logic [7:0] atk_type1,
    input  logic [7:0] atk_type2,
    output logic [8:0] dmg
);

    function automatic logic [7:0] sat_floor1(input logic signed [9:0] x);
        if (x < 10'sd1)
            return 8'd1;
        else
            return 8'(x);
    endfunction

    logic [14:0]        prod;
    logic [7:0]         raw;
    logic signed [9:0]  diff;
    logic [7:0]         base;
    logic               stab;

    always_comb begin
        // Product deliberately kept to 15 bits before the >> 7 scaling.
        prod = 15'({7'd0, power} * {7'd0, atk_stat});
        raw  = prod[14:7];
        diff = $signed({2'b00, raw}) - $signed({2'b00, def_stat >> 3});
        base = sat_floor1(diff);
        stab = (move_type == atk_type1) || (move_type == atk_type2);
        dmg  = stab ? ({1'b0, base} + {2'b00, base[7:1]}) : {1'b0, base};
    end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battle turn sequencer: HP init, speed order, per-attacker ROM fetch, hit/damage resolve.
module battle_turn_ctrl
    import battle_pkg::*;
#(
    parameter int MON_W        = 3,
    parameter int MOVE_W       = 5,
    parameter int HP_W         = 9,
    parameter int MAX_TURN_CYC = 40
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              new_battle,
    input  logic              start_turn,
    input  logic [MON_W-1:0]  p_mon,
    input  logic [MON_W-1:0]  c_mon,
    input  logic [MOVE_W-1:0] p_move,
    input  logic [MOVE_W-1:0] c_move,
    input  logic [6:0]        rand_in,
    output logic [5:0]        pokemon_addr,
    input  logic [7:0]        pokemon_data,
    output logic [7:0]        move_addr,
    input  logic [7:0]        move_data,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   c_hp,
    output logic              p_faint,
    output logic              c_faint,
    output logic              busy,
    output logic              done,
    output logic              player_first,
    output logic              p_hit,
    output logic              c_hit
);

    localparam logic [3:0] PAIR_LAST  = 4'd3;
    localparam logic [3:0] FETCH_LAST = 4'd9;
    localparam int         TURN_CYC   = 4 + 2 * (10 + 2) + 1;

    if (TURN_CYC > MAX_TURN_CYC) begin : g_latency_check
        $error("battle_turn_ctrl: turn sequence longer than MAX_TURN_CYC");
    end

    function automatic logic [5:0] stat_addr(input logic [MON_W-1:0] mon, input logic [2:0] field);
        return 6'({mon, field});
    endfunction

    function automatic logic [7:0] move_rom_addr(input logic [MOVE_W-1:0] mv, input logic [2:0] field);
        return 8'(mv) * 8'd5 + 8'(field);
    endfunction

    function automatic logic [HP_W-1:0] hp_sub_sat(input logic [HP_W-1:0] hp, input logic [8:0] d);
        logic signed [HP_W+1:0] r;
        r = $signed((HP_W+2)'(hp)) - $signed((HP_W+2)'(d));
        return (r < 0) ? '0 : HP_W'(r);
    endfunction

    turn_state_e       state, state_nxt;
    logic [3:0]        step;
    logic [MON_W-1:0]  p_mon_r, c_mon_r, atk_mon, def_mon;
    logic [MOVE_W-1:0] p_move_r, c_move_r, atk_move;
    logic              atk_is_p, second;
    logic [7:0]        spe_p0;
    logic [7:0]        mv_type, mv_cat, mv_pow, mv_acc;
    logic [7:0]        atk_t1, atk_t2, atk_stat, def_stat;
    logic [8:0]        dmg, dmg_p1;
    logic              hit, hit_p1;
    logic              rd_en, rd_is_move;
    logic [5:0]        rd_stat_addr;
    logic [7:0]        rd_move_addr;
    logic [HP_W-1:0]   def_hp, def_hp_new;
    logic              cmd_turn_ok;

    always_comb begin
        atk_mon    = atk_is_p ? p_mon_r : c_mon_r;
        def_mon    = atk_is_p ? c_mon_r : p_mon_r;
        atk_move   = atk_is_p ? p_move_r : c_move_r;
        hit        = (mv_acc >= 8'd100) || ({1'b0, rand_in} < mv_acc);
        def_hp     = atk_is_p ? c_hp : p_hp;
        def_hp_new = hit_p1 ? hp_sub_sat(def_hp, dmg_p1) : def_hp;
        cmd_turn_ok = !(p_faint || c_faint);
    end

    damage_calc u_damage (
        .power     (mv_pow),
        .atk_stat  (atk_stat),
        .def_stat  (def_stat),
        .move_type (mv_type),
        .atk_type1 (atk_t1),
        .atk_type2 (atk_t2),
        .dmg       (dmg)
    );

    // Address for step N goes out at the end of step N; its data is captured in step N+2.
    always_comb begin
        rd_en        = 1'b0;
        rd_is_move   = 1'b0;
        rd_stat_addr = '0;
        rd_move_addr = '0;
        case (state)
            ST_INIT: begin
                rd_en        = (step < 4'd2);
                rd_stat_addr = stat_addr(step[0] ? c_mon_r : p_mon_r, STAT_HP);
            end
            ST_SPEED: begin
                rd_en        = (step < 4'd2);
                rd_stat_addr = stat_addr(step[0] ? c_mon_r : p_mon_r, STAT_SPE);
            end
            ST_FETCH: begin
                rd_en = (step < 4'd8);
                case (step)
                    4'd0: begin rd_is_move = 1'b1; rd_move_addr = move_rom_addr(atk_move, MV_TYPE); end
                    4'd1: begin rd_is_move = 1'b1; rd_move_addr = move_rom_addr(atk_move, MV_CAT);  end
                    4'd2: begin rd_is_move = 1'b1; rd_move_addr = move_rom_addr(atk_move, MV_POW);  end
                    4'd3: begin rd_is_move = 1'b1; rd_move_addr = move_rom_addr(atk_move, MV_ACC);  end
                    4'd4: rd_stat_addr = stat_addr(atk_mon, STAT_TYPE1);
                    4'd5: rd_stat_addr = stat_addr(atk_mon, STAT_TYPE2);
                    4'd6: rd_stat_addr = stat_addr(atk_mon, (mv_cat == PHYSICAL) ? STAT_ATK : STAT_SPA);
                    4'd7: rd_stat_addr = stat_addr(def_mon, (mv_cat == PHYSICAL) ? STAT_DEF : STAT_SPD);
                    default: rd_en = 1'b0;
                endcase
            end
            default: rd_en = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (new_battle)
                    state_nxt = ST_INIT;
                else if (start_turn)
                    state_nxt = cmd_turn_ok ? ST_SPEED : ST_DONE;
            end
            ST_INIT:  if (step == PAIR_LAST)  state_nxt = ST_DONE;
            ST_SPEED: if (step == PAIR_LAST)  state_nxt = ST_FETCH;
            ST_FETCH: if (step == FETCH_LAST) state_nxt = ST_CALC;
            ST_CALC:  state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = (def_hp_new == '0 || second) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Latched ids and fetched operands carry no reset; they are always written before use.
    always_ff @(posedge Clk) begin
        if (state == ST_IDLE && new_battle) begin
            p_mon_r <= p_mon;
            c_mon_r <= c_mon;
        end
        if (state == ST_IDLE && !new_battle && start_turn) begin
            p_move_r <= p_move;
            c_move_r <= c_move;
        end
        if (state == ST_SPEED && step == 4'd2)
            spe_p0 <= pokemon_data;
        if (state == ST_FETCH) begin
            case (step)
                4'd2:    mv_type  <= move_data;
                4'd3:    mv_cat   <= move_data;
                4'd4:    mv_pow   <= move_data;
                4'd5:    mv_acc   <= move_data;
                4'd6:    atk_t1   <= pokemon_data;
                4'd7:    atk_t2   <= pokemon_data;
                4'd8:    atk_stat <= pokemon_data;
                4'd9:    def_stat <= pokemon_data;
                default: ;
            endcase
        end
        if (state == ST_CALC) begin
            dmg_p1 <= dmg;
            hit_p1 <= hit;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            step         <= '0;
            pokemon_addr <= '0;
            move_addr    <= '0;
            p_hp         <= '0;
            c_hp         <= '0;
            p_faint      <= 1'b0;
            c_faint      <= 1'b0;
            player_first <= 1'b0;
            p_hit        <= 1'b0;
            c_hit        <= 1'b0;
            atk_is_p     <= 1'b0;
            second       <= 1'b0;
        end else begin
            step <= (state_nxt != state || state == ST_IDLE) ? 4'd0 : step + 4'd1;
            if (rd_en) begin
                if (rd_is_move)
                    move_addr <= rd_move_addr;
                else
                    pokemon_addr <= rd_stat_addr;
            end
            case (state)
                ST_IDLE: begin
                    if (!new_battle && start_turn && cmd_turn_ok) begin
                        p_hit <= 1'b0;
                        c_hit <= 1'b0;
                    end
                end
                ST_INIT: begin
                    if (step == 4'd2) p_hp <= HP_W'({pokemon_data, 1'b0});
                    if (step == 4'd3) c_hp <= HP_W'({pokemon_data, 1'b0});
                    p_faint <= 1'b0;
                    c_faint <= 1'b0;
                end
                ST_SPEED: begin
                    if (step == PAIR_LAST) begin
                        player_first <= (spe_p0 >= pokemon_data);
                        atk_is_p     <= (spe_p0 >= pokemon_data);
                        second       <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (atk_is_p) begin
                        c_hp    <= def_hp_new;
                        c_faint <= (def_hp_new == '0);
                        p_hit   <= hit_p1;
                    end else begin
                        p_hp    <= def_hp_new;
                        p_faint <= (def_hp_new == '0);
                        c_hit   <= hit_p1;
                    end
                    if (state_nxt == ST_FETCH) begin
                        atk_is_p <= ~atk_is_p;
                        second   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
